// File: rtl/ahb_bm_pkg.sv
// Shared AHB encodings and burst helpers for the bus-matrix output stage.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Remaining-beat reload on NONSEQ: burst length minus two (last beat releases hold).
    function automatic logic [3:0] burst_remain(input hburst_e hburst);
        logic [3:0] rem;
        case (hburst)
            HBURST_INCR16, HBURST_WRAP16: rem = 4'd14;
            HBURST_INCR8,  HBURST_WRAP8:  rem = 4'd6;
            HBURST_INCR4,  HBURST_WRAP4:  rem = 4'd2;
            default:                      rem = 4'd0;
        endcase
        return rem;
    endfunction

endpackage

// File: rtl/ahb_bm_burst_tracker.sv
// Tracks burst progress on the granted port and decides whether arbitration is held.
module ahb_bm_burst_tracker
    import ahb_bm_pkg::*;
#(
    parameter int INCR_HOLD_BEATS  = 4,
    parameter int EARLY_INCR_LIMIT = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold,
    output logic       burst_hold
);

    logic [3:0] remain_r;
    logic [3:0] remain_nxt_s;
    logic       hold_r;
    logic       hold_nxt_s;
    logic [1:0] early_r;
    logic [1:0] early_nxt_s;

    // Next burst counter and hold flag from the current transfer.
    always_comb begin
        remain_nxt_s = remain_r;
        hold_nxt_s   = hold_r;
        if (!HSELM) begin
            remain_nxt_s = 4'd0;
            hold_nxt_s   = 1'b0;
        end else begin
            case (htrans_e'(HTRANSM))
                HTRANS_IDLE: begin
                    remain_nxt_s = 4'd0;
                    hold_nxt_s   = 1'b0;
                end
                HTRANS_BUSY: begin
                    remain_nxt_s = remain_r;
                    hold_nxt_s   = hold_r;
                end
                HTRANS_SEQ: begin
                    if (remain_r == 4'd0) begin
                        remain_nxt_s = 4'd0;
                        hold_nxt_s   = 1'b0;
                    end else begin
                        remain_nxt_s = remain_r - 4'd1;
                        hold_nxt_s   = hold_r;
                    end
                end
                HTRANS_NONSEQ: begin
                    if (hburst_e'(HBURSTM) == HBURST_INCR) begin
                        // Repeated early-terminated INCRs stop holding to avoid starving others
                        if (early_r >= 2'(EARLY_INCR_LIMIT)) begin
                            remain_nxt_s = 4'd0;
                            hold_nxt_s   = 1'b0;
                        end else begin
                            remain_nxt_s = 4'(INCR_HOLD_BEATS - 2);
                            hold_nxt_s   = 1'b1;
                        end
                    end else begin
                        remain_nxt_s = burst_remain(hburst_e'(HBURSTM));
                        hold_nxt_s   = (hburst_e'(HBURSTM) != HBURST_SINGLE);
                    end
                end
                default: begin
                    remain_nxt_s = 4'd0;
                    hold_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Early-INCR counter: counts bursts cut short by a new NONSEQ while still held.
    always_comb begin
        early_nxt_s = early_r;
        if (!hold_nxt_s) begin
            early_nxt_s = 2'd0;
        end else if (hold_r && (HTRANSM == HTRANS_NONSEQ) && (early_r < 2'(EARLY_INCR_LIMIT))) begin
            early_nxt_s = early_r + 2'd1;
        end else begin
            early_nxt_s = early_r;
        end
    end

    // Tracker state register, advancing only on accepted transfers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain_r <= 4'd0;
            hold_r   <= 1'b0;
            early_r  <= 2'd0;
        end else if (HREADYM) begin
            remain_r <= remain_nxt_s;
            hold_r   <= hold_nxt_s;
            early_r  <= early_nxt_s;
        end
    end

    assign next_hold  = hold_nxt_s;
    assign burst_hold = hold_r;

endmodule

// File: rtl/ahb_bm_output_arbiter_n.sv
// Per-slave output-stage arbiter: selects which input stage drives the shared slave.
module ahb_bm_output_arbiter_n
    import ahb_bm_pkg::*;
#(
    parameter int  NUM_PORTS        = 4,
    parameter int  INCR_HOLD_BEATS  = 4,
    parameter int  EARLY_INCR_LIMIT = 1,
    localparam int PORT_W           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    input  logic                 fixed_prio,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic [NUM_PORTS-1:0] addr_in_port_oh,
    output logic                 no_port,
    output logic                 burst_hold
);

    logic                 next_hold_s;
    logic [PORT_W-1:0]    port_r;
    logic [PORT_W-1:0]    port_nxt_s;
    logic                 no_port_r;
    logic                 no_port_nxt_s;
    logic [NUM_PORTS-1:0] oh_r;
    logic [NUM_PORTS-1:0] oh_nxt_s;
    logic [PORT_W-1:0]    low_sel_s;
    logic                 low_any_s;
    logic [PORT_W-1:0]    rr_sel_s;
    logic                 rr_any_s;
    int                   rr_idx_s;
    logic [NUM_PORTS-1:0] fp_cand_s;
    logic [PORT_W-1:0]    fp_sel_s;
    logic                 fp_any_s;

    ahb_bm_burst_tracker #(
        .INCR_HOLD_BEATS  (INCR_HOLD_BEATS),
        .EARLY_INCR_LIMIT (EARLY_INCR_LIMIT)
    ) u_tracker (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADYM    (HREADYM),
        .HSELM      (HSELM),
        .HTRANSM    (HTRANSM),
        .HBURSTM    (HBURSTM),
        .next_hold  (next_hold_s),
        .burst_hold (burst_hold)
    );

    // Lowest-index requester, used when nobody currently owns the slave.
    always_comb begin
        low_sel_s = port_r;
        low_any_s = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_port[i]) begin
                low_sel_s = PORT_W'(i);
                low_any_s = 1'b1;
            end else begin
                low_any_s = low_any_s;
            end
        end
    end

    // Round-robin: first requester after the current owner, owner itself excluded.
    always_comb begin
        rr_sel_s = port_r;
        rr_any_s = 1'b0;
        rr_idx_s = 0;
        for (int k = NUM_PORTS - 1; k >= 1; k--) begin
            rr_idx_s = (int'(port_r) + k) % NUM_PORTS;
            if (req_port[rr_idx_s]) begin
                rr_sel_s = PORT_W'(rr_idx_s);
                rr_any_s = 1'b1;
            end else begin
                rr_any_s = rr_any_s;
            end
        end
    end

    // Fixed priority: the owner's request is represented by its HSELM.
    always_comb begin
        fp_cand_s         = req_port;
        fp_cand_s[port_r] = HSELM;
        fp_sel_s          = port_r;
        fp_any_s          = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (fp_cand_s[i]) begin
                fp_sel_s = PORT_W'(i);
                fp_any_s = 1'b1;
            end else begin
                fp_any_s = fp_any_s;
            end
        end
    end

    // Grant decision and one-hot encoding.
    always_comb begin
        port_nxt_s    = port_r;
        no_port_nxt_s = no_port_r;
        if (HMASTLOCKM || next_hold_s) begin
            port_nxt_s    = port_r;
            no_port_nxt_s = 1'b0;
        end else if (no_port_r) begin
            port_nxt_s    = low_any_s ? low_sel_s : port_r;
            no_port_nxt_s = !low_any_s;
        end else if (!fixed_prio) begin
            port_nxt_s    = rr_any_s ? rr_sel_s : port_r;
            no_port_nxt_s = !(rr_any_s || HSELM);
        end else begin
            port_nxt_s    = fp_any_s ? fp_sel_s : port_r;
            no_port_nxt_s = !fp_any_s;
        end

        oh_nxt_s = {NUM_PORTS{1'b0}};
        if (!no_port_nxt_s) begin
            oh_nxt_s[port_nxt_s] = 1'b1;
        end else begin
            oh_nxt_s = {NUM_PORTS{1'b0}};
        end
    end

    // Grant registers, advancing only on accepted transfers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            port_r    <= {PORT_W{1'b0}};
            no_port_r <= 1'b1;
            oh_r      <= {NUM_PORTS{1'b0}};
        end else if (HREADYM) begin
            port_r    <= port_nxt_s;
            no_port_r <= no_port_nxt_s;
            oh_r      <= oh_nxt_s;
        end
    end

    assign addr_in_port    = port_r;
    assign addr_in_port_oh = oh_r;
    assign no_port         = no_port_r;

endmodule

// File: tb/tb_ahb_bm_output_arbiter_n.sv
// Directed plus randomized bench for the output-stage arbiter against a burst-length model.
module tb_ahb_bm_output_arbiter_n;

    localparam int N  = 4;
    localparam int HB = 4;
    localparam int EL = 1;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] req_port;
    logic         HREADYM;
    logic         HSELM;
    logic [1:0]   HTRANSM;
    logic [2:0]   HBURSTM;
    logic         HMASTLOCKM;
    logic         fixed_prio;
    logic [1:0]   addr_in_port;
    logic [N-1:0] addr_in_port_oh;
    logic         no_port;
    logic         burst_hold;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner, idle flag, SEQ beats still inside the held burst, early-INCR count
    int m_port;
    bit m_nop;
    bit m_hold;
    int m_left;
    int m_early;

    ahb_bm_output_arbiter_n #(
        .NUM_PORTS        (N),
        .INCR_HOLD_BEATS  (HB),
        .EARLY_INCR_LIMIT (EL)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .req_port        (req_port),
        .HREADYM         (HREADYM),
        .HSELM           (HSELM),
        .HTRANSM         (HTRANSM),
        .HBURSTM         (HBURSTM),
        .HMASTLOCKM      (HMASTLOCKM),
        .fixed_prio      (fixed_prio),
        .addr_in_port    (addr_in_port),
        .addr_in_port_oh (addr_in_port_oh),
        .no_port         (no_port),
        .burst_hold      (burst_hold)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_port  = 0;
        m_nop   = 1'b1;
        m_hold  = 1'b0;
        m_left  = 0;
        m_early = 0;
    endtask

    function automatic int burst_len(input logic [2:0] hb, input int early);
        case (hb)
            3'b000:         return 1;
            3'b001:         return (early >= EL) ? 1 : HB;
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    task automatic model_step();
        bit           nh;
        int           nl;
        bit           any;
        int           pick;
        logic [N-1:0] cand;
        nh   = m_hold;
        nl   = m_left;
        any  = 1'b0;
        pick = m_port;
        if (!HSELM || HTRANSM == 2'b00) begin
            nh = 1'b0;
            nl = 0;
        end else if (HTRANSM == 2'b11) begin
            if (nl > 0) nl--;
            nh = (nl > 0);
        end else if (HTRANSM == 2'b10) begin
            nl = burst_len(HBURSTM, m_early) - 1;
            nh = (nl > 0);
        end
        if (!nh) m_early = 0;
        else if (m_hold && HTRANSM == 2'b10 && m_early < EL) m_early++;

        if (HMASTLOCKM || nh) begin
            m_nop = 1'b0;
        end else if (m_nop) begin
            for (int i = 0; i < N; i++)
                if (!any && req_port[i]) begin any = 1'b1; pick = i; end
            if (any) begin m_port = pick; m_nop = 1'b0; end
        end else if (!fixed_prio) begin
            for (int k = 1; k < N; k++)
                if (!any && req_port[(m_port + k) % N]) begin any = 1'b1; pick = (m_port + k) % N; end
            if (any) m_port = pick;
            else if (!HSELM) m_nop = 1'b1;
        end else begin
            cand = req_port;
            cand[m_port] = HSELM;
            for (int i = 0; i < N; i++)
                if (!any && cand[i]) begin any = 1'b1; pick = i; end
            if (any) m_port = pick;
            else m_nop = 1'b1;
        end
        m_hold = nh;
        m_left = nl;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_oh;
        exp_oh = m_nop ? 32'd0 : (32'd1 << m_port);
        check({tag, ".port"}, 32'(addr_in_port), 32'(m_port));
        check({tag, ".oh"}, 32'(addr_in_port_oh), exp_oh);
        check({tag, ".no_port"}, 32'(no_port), 32'(m_nop));
        check({tag, ".hold"}, 32'(burst_hold), 32'(m_hold));
    endtask

    task automatic cycle(input string tag);
        @(posedge HCLK);
        if (HREADYM) model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic bus(input logic sel, input logic [1:0] tr, input logic [2:0] bu);
        HSELM   = sel;
        HTRANSM = tr;
        HBURSTM = bu;
    endtask

    initial begin
        HRESETn    = 1'b0;
        HREADYM    = 1'b1;
        HMASTLOCKM = 1'b0;
        fixed_prio = 1'b0;
        req_port   = 4'b0000;
        bus(1'b0, 2'b00, 3'b000);
        model_reset();
        #12;
        check_outputs("reset");
        check("reset_nop_const", 32'(no_port), 32'd1);
        HRESETn = 1'b1;

        // First grant from idle goes to the lowest requester
        req_port = 4'b0110;
        cycle("tp1");
        check("tp1_port", 32'(addr_in_port), 32'd1);
        check("tp1_oh", 32'(addr_in_port_oh), 32'b0010);

        // Round-robin wrap from port 3 to port 0, then onward to 1
        req_port = 4'b1000;
        bus(1'b1, 2'b00, 3'b000);
        cycle("rr_to3");
        check("rr_to3_port", 32'(addr_in_port), 32'd3);
        req_port = 4'b0011;
        bus(1'b1, 2'b10, 3'b000);
        cycle("rr_wrap");
        check("rr_wrap_port", 32'(addr_in_port), 32'd0);
        cycle("rr_next");
        check("rr_next_port", 32'(addr_in_port), 32'd1);

        // Fixed priority with HSELM standing in for the owner
        req_port = 4'b0100;
        cycle("rr_to2");
        check("rr_to2_port", 32'(addr_in_port), 32'd2);
        fixed_prio = 1'b1;
        req_port   = 4'b1010;
        cycle("fp_a");
        check("fp_a_port", 32'(addr_in_port), 32'd1);
        req_port = 4'b1000;
        cycle("fp_b");
        check("fp_b_port", 32'(addr_in_port), 32'd1);

        // INCR8 on port 0 with a BUSY and wait states inside the burst
        req_port = 4'b0001;
        bus(1'b1, 2'b00, 3'b000);
        cycle("to0");
        check("to0_port", 32'(addr_in_port), 32'd0);
        fixed_prio = 1'b0;
        req_port   = 4'b0010;
        bus(1'b1, 2'b10, 3'b101);
        cycle("i8_b1");
        check("i8_b1_port", 32'(addr_in_port), 32'd0);
        bus(1'b1, 2'b11, 3'b101);
        cycle("i8_b2");
        cycle("i8_b3");
        bus(1'b1, 2'b01, 3'b101);
        cycle("i8_busy");
        bus(1'b1, 2'b11, 3'b101);
        HREADYM = 1'b0;
        cycle("i8_stall1");
        cycle("i8_stall2");
        check("i8_stall_hold", 32'(burst_hold), 32'd1);
        HREADYM = 1'b1;
        for (int b = 4; b <= 7; b++) begin
            cycle("i8_beat");
            check("i8_beat_port", 32'(addr_in_port), 32'd0);
        end
        cycle("i8_b8");
        check("i8_b8_port", 32'(addr_in_port), 32'd1);

        // Early-terminated INCRs: the third stops holding
        fixed_prio = 1'b1;
        req_port   = 4'b0001;
        bus(1'b1, 2'b00, 3'b000);
        cycle("to0b");
        fixed_prio = 1'b0;
        req_port   = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            bus(1'b1, 2'b10, 3'b001);
            cycle("incr_ns");
            check("incr_ns_port", 32'(addr_in_port), 32'd0);
            bus(1'b1, 2'b11, 3'b001);
            cycle("incr_seq");
            check("incr_seq_port", 32'(addr_in_port), 32'd0);
        end
        bus(1'b1, 2'b10, 3'b001);
        cycle("incr3");
        check("incr3_port", 32'(addr_in_port), 32'd2);
        check("incr3_hold", 32'(burst_hold), 32'd0);

        // Locked transfers keep the grant even with HSELM low
        HMASTLOCKM = 1'b1;
        req_port   = 4'b1001;
        bus(1'b1, 2'b00, 3'b000);
        cycle("lock1");
        bus(1'b0, 2'b00, 3'b000);
        cycle("lock2");
        check("lock2_port", 32'(addr_in_port), 32'd2);
        HMASTLOCKM = 1'b0;
        req_port   = 4'b1000;
        cycle("unlock");
        check("unlock_port", 32'(addr_in_port), 32'd3);

        // Async reset in the middle of a held WRAP16 with the bus stalled
        bus(1'b1, 2'b10, 3'b110);
        cycle("w16");
        check("w16_hold", 32'(burst_hold), 32'd1);
        HREADYM = 1'b0;
        bus(1'b1, 2'b11, 3'b110);
        #3;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst");
        check("midrst_oh", 32'(addr_in_port_oh), 32'd0);
        check("midrst_hold", 32'(burst_hold), 32'd0);
        #10;
        HRESETn = 1'b1;
        HREADYM = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            req_port   = 4'($urandom_range(0, 15));
            HREADYM    = ($urandom_range(0, 4) != 0);
            HSELM      = ($urandom_range(0, 9) != 0);
            HTRANSM    = 2'($urandom_range(0, 3));
            HBURSTM    = 3'($urandom_range(0, 7));
            HMASTLOCKM = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) fixed_prio = ~fixed_prio;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bm_output_arbiter_n.md
Name: ahb_bm_output_arbiter_n

Overview:
- Parametrised output-stage arbiter for the custom AHB bus matrix, one instance per slave (output) port.
- Chooses which of NUM_PORTS input stages drives the shared slave. Holds the grant across locked transfers, fixed-length bursts and short INCR bursts.
- Next-generation arbiter: N-port generalisation, run-time round-robin/fixed-priority select, configurable INCR hold length and early-INCR limit, one-hot grant and burst-hold status outputs.

Parameters:
- NUM_PORTS, 4: number of input stages requesting this slave; legal range 2..16.
- INCR_HOLD_BEATS, 4: beats for which an undefined-length INCR burst holds arbitration; legal range 2..16.
- EARLY_INCR_LIMIT, 1: number of back-to-back early-terminated held INCR bursts after which INCR no longer holds; legal range 1..3.
- PORT_W, max(1,$clog2(NUM_PORTS)): derived localparam, not overridable.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  asynchronous active-low reset
- req_port  in  NUM_PORTS  per-input-stage request; bit i = port i
- HREADYM  in  1  transfer done on the output bus
- HSELM  in  1  slave select from the currently granted port
- HTRANSM  in  2  transfer type
- HBURSTM  in  3  burst type
- HMASTLOCKM  in  1  locked transfer
- fixed_prio  in  1  0 = round-robin, 1 = fixed priority (port 0 highest)
- addr_in_port  out  PORT_W  granted port index
- addr_in_port_oh  out  NUM_PORTS  one-hot grant; all zero when no_port=1
- no_port  out  1  no input port granted
- burst_hold  out  1  registered burst-hold state

Behaviour:
- Reset is asynchronous (HRESETn low). Reset values: no_port=1, addr_in_port=0, addr_in_port_oh=0, burst_hold=0, burst counter 0, early-INCR count 0.
- All state registers update only on a rising HCLK edge with HREADYM=1; they hold otherwise.
- Outputs are registered state; the arbitration decision takes effect one accepted HREADYM cycle later.
- Burst tracker, next-state values:
  - HSELM=0: remain=0, hold=0.
  - IDLE: remain=0, hold=0.
  - BUSY: hold the current remain and hold values.
  - SEQ: if remain=0, set hold=0 and keep remain=0; else remain-1 and keep hold.
  - NONSEQ, INCR16/WRAP16: remain=14, hold=1.
  - NONSEQ, INCR8/WRAP8: remain=6, hold=1.
  - NONSEQ, INCR4/WRAP4: remain=2, hold=1.
  - NONSEQ, SINGLE: remain=0, hold=0.
  - NONSEQ, INCR: if early_count >= EARLY_INCR_LIMIT, remain=0, hold=0; else remain=INCR_HOLD_BEATS-2, hold=1.
  - remain is 4 bits. All HTRANS/HBURST codes are defined; there are no X branches.
- Early-INCR count:
  - next_hold=0: cleared.
  - Current hold=1 and HTRANSM=NONSEQ: increments, saturating at EARLY_INCR_LIMIT.
  - Otherwise: holds.
- Arbitration, evaluated with next_hold:
  - HMASTLOCKM=1 or next_hold=1: keep addr_in_port; no_port is forced to 0.
  - Else if no_port=1: lowest-index asserted req_port wins in both modes. No request keeps no_port=1 and addr_in_port unchanged.
  - Else if fixed_prio=0 (round-robin): scan ports cur+1, cur+2, … modulo NUM_PORTS, excluding cur; the first requester wins. No other requester and HSELM=1: keep cur. Otherwise no_port=1, addr_in_port unchanged. req_port[cur] is ignored; HSELM stands in for the current port.
  - Else (fixed priority): the candidate set is req_port with bit cur replaced by HSELM. The lowest index in the set wins; an empty set gives no_port=1.
- fixed_prio may change at any cycle; it is sampled combinationally with the other arbitration inputs.
- Locked and held bursts keep the grant even if the granted port deasserts its request.
- Boundaries:
  - cur=NUM_PORTS-1 wraps its scan to port 0.
  - No grant is ever issued to an index >= NUM_PORTS.
  - If the granted port drops HSELM mid-burst, hold clears in the same decision.
- Reset asserted mid-burst: all state returns to reset values immediately, without waiting for HREADYM.

Decomposition:
- Package ahb_bm_pkg holds:
  - HTRANS encodings: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
  - HBURST encodings: SINGLE 000 … INCR16 111.
  - Function burst_remain(hburst) returning the NONSEQ reload value.
- Sub-module ahb_bm_burst_tracker: burst counter, hold and early-INCR count; outputs next_hold and burst_hold.
- The top level holds the port selection logic (round-robin rotate-and-priority-encode and fixed-priority encoder) and the grant registers.

Test Plan:
- Reset, then req_port=4'b0110 with HREADYM=1 → after 1 edge no_port=0, addr_in_port=1, addr_in_port_oh=4'b0010.
- Round-robin, grant=3, HSELM=1, req_port=4'b0011, SINGLE NONSEQ → grant 0 next (wrap); then with req_port=4'b0011 → grant 1.
- Fixed priority, grant=2, HSELM=1, req_port=4'b1010 → grant 1; then req_port=4'b1000, HSELM=1 → grant stays 1.
- Grant=0, NONSEQ INCR8 followed by 7 SEQ, req_port[1]=1 throughout → grant stays 0 for 7 accepted beats and moves to 1 on the 8th. A BUSY inserted mid-burst plus HREADYM=0 stalls extend the hold with no counter change.
- Defaults, two back-to-back 2-beat INCR bursts then a third NONSEQ INCR with req_port[2]=1 → third burst holds no grant; grant moves to 2 after its first beat. HMASTLOCKM=1 keeps the grant regardless.
- Assert HRESETn=0 during a held WRAP16 with HREADYM=0 → outputs go to no_port=1, addr_in_port=0, oh=0, burst_hold=0 immediately.
